// File: rtl/data_memory_bank.sv
// Single-port synchronous data memory with a zero-fill sequencer, byte-lane writes, a read-valid strobe and an address range check.
// Optional build macro DMEM_OUT_REG_EN adds an output register stage, which makes the read latency 2.
module data_memory_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  writeEnable,
    input  logic [DATA_W/8-1:0]   byteEn,
    input  logic [ADDR_W-1:0]     addrData,
    input  logic [DATA_W-1:0]     writeData,
    output logic [DATA_W-1:0]     readData,
    output logic                  readValid,
    output logic                  addrError,
    output logic                  ready,
    input  logic                  initStart
);

    localparam int                LANES     = DATA_W / 8;
    localparam logic [0:0]        S_INIT    = 1'b0;
    localparam logic [0:0]        S_READY   = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [0:0]        state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              ready_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              addr_err_r;

    logic              in_range_s;
    logic              accept_s;
    logic              rd_acc_s;
    logic              wr_acc_s;

    // Qualify requests: only in S_READY, and initStart takes priority over a same-cycle request.
    always_comb begin
        in_range_s = ({1'b0, addrData} < DEPTH_LIM);
        accept_s   = 1'b0;
        if ((state_r == S_READY) && ready_r && !initStart) begin
            accept_s = req;
        end else begin
            accept_s = 1'b0;
        end
        rd_acc_s = accept_s & ~writeEnable;
        wr_acc_s = accept_s & writeEnable;
    end

    // Fill sequencer: walks every word once, then raises ready on the edge that clears the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_INIT;
            cnt_r   <= {ADDR_W{1'b0}};
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                S_INIT: begin
                    if (cnt_r == LAST_ADDR) begin
                        state_r <= S_READY;
                        cnt_r   <= {ADDR_W{1'b0}};
                        ready_r <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + ADDR_W'(1);
                    end
                end
                S_READY: begin
                    if (initStart) begin
                        state_r <= S_INIT;
                        cnt_r   <= {ADDR_W{1'b0}};
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_INIT;
                    cnt_r   <= {ADDR_W{1'b0}};
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: the array is not reset; its contents are defined only by the fill and by lane writes.
    always_ff @(posedge clk) begin
        if (state_r == S_INIT) begin
            mem_r[cnt_r] <= {DATA_W{1'b0}};
        end else if (wr_acc_s && in_range_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (byteEn[i]) begin
                    mem_r[addrData][8*i +: 8] <= writeData[8*i +: 8];
                end
            end
        end
    end

    // Read port and strobes: readData holds between reads, and an out-of-range read returns zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
            addr_err_r <= 1'b0;
        end else if (rd_acc_s) begin
            rd_valid_r <= 1'b1;
            if (in_range_s) begin
                rd_data_r  <= mem_r[addrData];
                addr_err_r <= 1'b0;
            end else begin
                rd_data_r  <= {DATA_W{1'b0}};
                addr_err_r <= 1'b1;
            end
        end else if (wr_acc_s) begin
            rd_valid_r <= 1'b0;
            addr_err_r <= ~in_range_s;
        end else begin
            rd_valid_r <= 1'b0;
            addr_err_r <= 1'b0;
        end
    end

`ifdef DMEM_OUT_REG_EN
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              out_err_r;

    // Output retiming stage: it is cleared only by rst_n, so an in-flight result survives initStart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            out_err_r   <= 1'b0;
        end else begin
            out_data_r  <= rd_data_r;
            out_valid_r <= rd_valid_r;
            out_err_r   <= addr_err_r;
        end
    end

    assign readData  = out_data_r;
    assign readValid = out_valid_r;
    assign addrError = out_err_r;
`else
    assign readData  = rd_data_r;
    assign readValid = rd_valid_r;
    assign addrError = addr_err_r;
`endif

    assign ready = ready_r;

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed, scoreboard-checked bench for data_memory_bank (DATA_W=16, ADDR_W=8, DEPTH=200).
// The bench follows DMEM_OUT_REG_EN so that it expects a read latency of 2 when the macro is defined.
module tb_data_memory_bank;

    localparam int DEPTH = 200;
`ifdef DMEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          due;
        logic        v;
        logic        e;
        logic [15:0] d;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        writeEnable;
    logic [1:0]  byteEn;
    logic [7:0]  addrData;
    logic [15:0] writeData;
    logic [15:0] readData;
    logic        readValid;
    logic        addrError;
    logic        ready;
    logic        initStart;

    exp_t        sb [$];
    logic [15:0] ref_mem [256];
    logic        rdy_m;
    int          cyc;
    int          tests;
    int          fails;

    data_memory_bank #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .writeEnable(writeEnable),
        .byteEn(byteEn), .addrData(addrData), .writeData(writeData),
        .readData(readData), .readValid(readValid), .addrError(addrError),
        .ready(ready), .initStart(initStart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its summary line");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then match any strobe against the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (readValid === 1'b1 || addrError === 1'b1) begin
            chk("spurious_strobe", (sb.size() == 0) ? 0 : 1, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("strobe_cycle", cyc, e.due);
                chk("readValid", {31'd0, readValid}, {31'd0, e.v});
                chk("addrError", {31'd0, addrError}, {31'd0, e.e});
                if (e.v) chk("readData", {16'd0, readData}, {16'd0, e.d});
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("missing_strobe", {30'd0, readValid, addrError}, {30'd0, e.v, e.e});
        end
    endtask

    task automatic access(input logic we, input logic [1:0] be, input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        req = 1'b1; writeEnable = we; byteEn = be; addrData = a; writeData = d;
        if (rdy_m) begin
            e.due = cyc + LAT;
            e.e   = (a >= 8'(DEPTH));
            if (!we) begin
                e.v = 1'b1;
                e.d = e.e ? 16'h0000 : ref_mem[a];
                sb.push_back(e);
            end else if (e.e) begin
                e.v = 1'b0;
                e.d = 16'h0000;
                sb.push_back(e);
            end else begin
                if (be[0]) ref_mem[a][7:0]  = d[7:0];
                if (be[1]) ref_mem[a][15:8] = d[15:8];
            end
        end
        tick();
        req = 1'b0; writeEnable = 1'b0;
    endtask

    // Count the edges until ready rises, then model the array as zero-filled.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 260; i++) begin
            tick();
            n++;
            if (ready === 1'b1) break;
        end
        req = 1'b0;
        chk(tag, n, DEPTH);
        rdy_m = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    endtask

    task automatic drain();
        repeat (LAT + 2) tick();
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; rdy_m = 1'b0;
        rst_n = 1'b0; req = 1'b0; writeEnable = 1'b0; byteEn = 2'b00;
        addrData = 8'h00; writeData = 16'h0000; initStart = 1'b0;

        // Reset state
        #12;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_readValid", {31'd0, readValid}, 32'd0);
        chk("rst_addrError", {31'd0, addrError}, 32'd0);
        chk("rst_readData", {16'd0, readData}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: fill takes DEPTH edges, then read a zeroed word
        wait_ready("fill_after_reset");
        access(1'b0, 2'b00, 8'd5, 16'h0000);
        drain();

        // 2: full write, read next cycle, readData held across a later write
        access(1'b1, 2'b11, 8'd1, 16'hAAAA);
        access(1'b0, 2'b00, 8'd1, 16'h0000);
        drain();
        access(1'b1, 2'b11, 8'd3, 16'h5555);
        drain();
        chk("readData_hold", {16'd0, readData}, 32'h0000AAAA);

        // 3: byte-lane merge, then a byteEn=0 write that must leave the word unchanged
        access(1'b1, 2'b11, 8'd2, 16'h1234);
        access(1'b1, 2'b01, 8'd2, 16'h00CD);
        access(1'b0, 2'b00, 8'd2, 16'h0000);
        access(1'b1, 2'b00, 8'd2, 16'hFFFF);
        access(1'b1, 2'b10, 8'd4, 16'h9A77);
        access(1'b0, 2'b00, 8'd2, 16'h0000);
        access(1'b0, 2'b00, 8'd4, 16'h0000);
        drain();

        // Back-to-back reads, including the last in-range word
        access(1'b1, 2'b11, 8'd199, 16'hC0DE);
        access(1'b0, 2'b00, 8'd1, 16'h0000);
        access(1'b0, 2'b00, 8'd2, 16'h0000);
        access(1'b0, 2'b00, 8'd199, 16'h0000);
        access(1'b0, 2'b00, 8'd3, 16'h0000);
        drain();

        // 4: out-of-range write and read
        access(1'b1, 2'b11, 8'd200, 16'hBEEF);
        access(1'b0, 2'b00, 8'd200, 16'h0000);
        access(1'b0, 2'b00, 8'd255, 16'h0000);
        drain();

        // 5: initStart with a same-cycle request, then reads during the fill get no response
        initStart = 1'b1; req = 1'b1; writeEnable = 1'b0; addrData = 8'd1;
        rdy_m = 1'b0;
        tick();
        initStart = 1'b0;
        chk("init_ready_low", {31'd0, ready}, 32'd0);
        wait_ready("fill_after_initStart");
        access(1'b0, 2'b00, 8'd1, 16'h0000);
        access(1'b0, 2'b00, 8'd2, 16'h0000);
        drain();

        // 6a: reset in the middle of a fill
        initStart = 1'b1;
        rdy_m = 1'b0;
        tick();
        initStart = 1'b0;
        repeat (50) tick();
        rst_n = 1'b0;
        #1;
        chk("midfill_rst_ready", {31'd0, ready}, 32'd0);
        chk("midfill_rst_readData", {16'd0, readData}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready("fill_after_midfill_reset");

        // 6b: reset while a read result is being presented
        access(1'b1, 2'b11, 8'd1, 16'hAAAA);
        access(1'b0, 2'b00, 8'd1, 16'h0000);
        repeat (LAT - 1) tick();
        chk("midread_valid_before_rst", {31'd0, readValid}, 32'd1);
        rst_n = 1'b0;
        rdy_m = 1'b0;
        #1;
        chk("midread_rst_readData", {16'd0, readData}, 32'd0);
        chk("midread_rst_readValid", {31'd0, readValid}, 32'd0);
        chk("midread_rst_addrError", {31'd0, addrError}, 32'd0);
        chk("midread_rst_ready", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready("fill_after_midread_reset");
        access(1'b0, 2'b00, 8'd1, 16'h0000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
